// File: rtl/nvdla_dbb_wr_sequencer.sv
`default_nettype none
// ============================================================================
// nvdla_dbb_wr_sequencer : buffers dbb AW/W, holds W behind issued AW,
// regenerates wlast, caps outstanding writes.          Revision 1.0
// ============================================================================

module nvdla_dbb_wr_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int c_PW = $clog2(DEPTH);
  localparam logic [c_PW:0] c_ONE = 1;

  logic [c_PW:0]      r_wr_ptr;
  logic [c_PW:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_push;
  logic               w_pop;

  // Extra pointer bit separates full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_PW] != r_rd_ptr[c_PW]) &&
                   (r_wr_ptr[c_PW-1:0] == r_rd_ptr[c_PW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr[c_PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_PW-1:0]] <= i_data;
  end
endmodule

module nvdla_dbb_wr_sequencer #(
  parameter int AW_DEPTH        = 4,
  parameter int W_DEPTH         = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        core_clk,
  input  logic        rstn,
  input  logic        nvdla_core2dbb_aw_awvalid,
  output logic        nvdla_core2dbb_aw_awready,
  input  logic [7:0]  nvdla_core2dbb_aw_awid,
  input  logic [3:0]  nvdla_core2dbb_aw_awlen,
  input  logic [31:0] nvdla_core2dbb_aw_awaddr,
  input  logic        nvdla_core2dbb_w_wvalid,
  output logic        nvdla_core2dbb_w_wready,
  input  logic [63:0] nvdla_core2dbb_w_wdata,
  input  logic [7:0]  nvdla_core2dbb_w_wstrb,
  input  logic        nvdla_core2dbb_w_wlast,
  output logic        nvdla_core2dbb_b_bvalid,
  input  logic        nvdla_core2dbb_b_bready,
  output logic [7:0]  nvdla_core2dbb_b_bid,
  output logic        mem_aw_awvalid,
  input  logic        mem_aw_awready,
  output logic [7:0]  mem_aw_awid,
  output logic [3:0]  mem_aw_awlen,
  output logic [2:0]  mem_aw_awsize,
  output logic [31:0] mem_aw_awaddr,
  output logic        mem_w_wvalid,
  input  logic        mem_w_wready,
  output logic [63:0] mem_w_wdata,
  output logic [7:0]  mem_w_wstrb,
  output logic        mem_w_wlast,
  input  logic        mem_b_bvalid,
  output logic        mem_b_bready,
  input  logic [7:0]  mem_b_bid,
  output logic        wlast_err,
  output logic        b_err,
  output logic        idle
);
  localparam int c_OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_OW-1:0] c_MAX_OUT = c_OW'(MAX_OUTSTANDING);
  localparam logic [c_OW-1:0] c_OUT_ONE = c_OW'(1);
  localparam logic [3:0]      c_BEAT_ONE = 4'd1;

  logic            w_aw_empty, w_aw_full;
  logic [43:0]     w_aw_head;
  logic            w_w_empty, w_w_full;
  logic [72:0]     w_w_head;
  logic            w_lq_empty, w_lq_full;
  logic [3:0]      w_lq_head;
  logic            w_core_wlast;
  logic            w_mem_aw_hs, w_mem_w_hs, w_w_last_hs, w_b_hs;
  logic [c_OW-1:0] r_outstanding;
  logic [3:0]      r_beat_cnt;
  logic            r_wlast_err, r_b_err;

  nvdla_dbb_wr_seq_fifo #(.WIDTH(44), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk(core_clk), .rst_n(rstn),
    .i_push(nvdla_core2dbb_aw_awvalid),
    .i_data({nvdla_core2dbb_aw_awid, nvdla_core2dbb_aw_awlen, nvdla_core2dbb_aw_awaddr}),
    .i_pop(w_mem_aw_hs), .o_data(w_aw_head), .o_empty(w_aw_empty), .o_full(w_aw_full)
  );

  // Lengths of bursts already issued to memory, in issue order.
  nvdla_dbb_wr_seq_fifo #(.WIDTH(4), .DEPTH(AW_DEPTH)) u_len_q (
    .clk(core_clk), .rst_n(rstn),
    .i_push(w_mem_aw_hs), .i_data(mem_aw_awlen),
    .i_pop(w_w_last_hs), .o_data(w_lq_head), .o_empty(w_lq_empty), .o_full(w_lq_full)
  );

  nvdla_dbb_wr_seq_fifo #(.WIDTH(73), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk(core_clk), .rst_n(rstn),
    .i_push(nvdla_core2dbb_w_wvalid),
    .i_data({nvdla_core2dbb_w_wdata, nvdla_core2dbb_w_wstrb, nvdla_core2dbb_w_wlast}),
    .i_pop(w_mem_w_hs), .o_data(w_w_head), .o_empty(w_w_empty), .o_full(w_w_full)
  );

  assign nvdla_core2dbb_aw_awready = ~w_aw_full;
  assign nvdla_core2dbb_w_wready   = ~w_w_full;

  // Gate terms only fall through an issue, so a raised valid stays up until awready.
  assign mem_aw_awvalid = ~w_aw_empty & (r_outstanding < c_MAX_OUT) & ~w_lq_full;
  assign {mem_aw_awid, mem_aw_awlen, mem_aw_awaddr} = w_aw_head;
  assign mem_aw_awsize  = 3'b011;

  assign mem_w_wvalid = ~w_w_empty & ~w_lq_empty;
  assign {mem_w_wdata, mem_w_wstrb, w_core_wlast} = w_w_head;
  assign mem_w_wlast  = (r_beat_cnt == w_lq_head);

  assign nvdla_core2dbb_b_bvalid = mem_b_bvalid;
  assign nvdla_core2dbb_b_bid    = mem_b_bid;
  assign mem_b_bready            = nvdla_core2dbb_b_bready;

  assign w_mem_aw_hs = mem_aw_awvalid & mem_aw_awready;
  assign w_mem_w_hs  = mem_w_wvalid & mem_w_wready;
  assign w_w_last_hs = w_mem_w_hs & mem_w_wlast;
  assign w_b_hs      = mem_b_bvalid & nvdla_core2dbb_b_bready;

  assign wlast_err = r_wlast_err;
  assign b_err     = r_b_err;
  assign idle      = w_aw_empty & w_w_empty & w_lq_empty & (r_outstanding == '0);

  always_ff @(posedge core_clk or negedge rstn) begin
    if (!rstn) begin
      r_outstanding <= '0;
      r_beat_cnt    <= '0;
      r_wlast_err   <= 1'b0;
      r_b_err       <= 1'b0;
    end else begin
      if (w_mem_w_hs) begin
        r_beat_cnt <= mem_w_wlast ? 4'd0 : r_beat_cnt + c_BEAT_ONE;
        if (w_core_wlast != mem_w_wlast) r_wlast_err <= 1'b1;
      end
      if (w_mem_aw_hs && !w_b_hs) begin
        r_outstanding <= r_outstanding + c_OUT_ONE;
      end else if (!w_mem_aw_hs && w_b_hs && (r_outstanding != '0)) begin
        r_outstanding <= r_outstanding - c_OUT_ONE;
      end
      if (w_b_hs && !w_mem_aw_hs && (r_outstanding == '0)) r_b_err <= 1'b1;
    end
  end
endmodule
`default_nettype wire
